writeback_buffer: RTL and testbench

- Line-granular eviction write buffer between the cache arbiter (upstream, 256-bit line port) and the cacheline adapter (downstream, 256-bit line port).
- Absorbs dirty-line writebacks in one cycle and drains them to memory when the downstream port is otherwise idle.
- Upstream reads that miss are forwarded ahead of pending writebacks. Reads that hit a buffered line are serviced from the buffer, so read-after-writeback ordering is preserved.

---
 rtl/writeback_buffer.sv | 189 ++++++++++++++++++
 tb/tb_writeback_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : writeback_buffer
// Brief    : Line-granular eviction write buffer between the cache arbiter
//            and the cacheline adapter. Absorbs dirty-line writebacks in one
//            cycle, coalesces writes to a buffered line, services read hits
//            from the buffer and forwards read misses ahead of pending drains.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_buffer #(
    parameter int DEPTH       = 2,
    parameter int OFFSET_BITS = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [255:0] mem_line_write,
    output logic [255:0] mem_line_read,
    output logic         mem_resp,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    output logic [255:0] line_o,
    input  logic [255:0] line_i,
    input  logic         resp_i
);

    localparam int c_TAG_W = 32 - OFFSET_BITS;
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0]     c_FULL        = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]     c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]     c_PTR_ONE     = c_PTR_W'(1);
    localparam logic [OFFSET_BITS-1:0] c_OFFSET_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FWD_READ = 2'd1,
        S_DRAIN    = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t               r_state;

    // Entry storage; slots are allocated at the tail and drained from the head.
    logic [DEPTH-1:0]     r_valid;
    logic [c_TAG_W-1:0]   r_tag  [DEPTH];
    logic [255:0]         r_data [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    // Registered port drivers.
    logic                 r_mem_resp;
    logic [255:0]         r_mem_line_read;
    logic                 r_read;
    logic                 r_write;
    logic [31:0]          r_address;
    logic [255:0]         r_line;

    logic [c_TAG_W-1:0]   w_tag;
    logic [DEPTH-1:0]     w_match;
    logic                 w_hit;
    logic [c_PTR_W-1:0]   w_hit_idx;
    logic                 w_full;
    logic                 w_unused_offset;

    assign w_tag           = mem_address[31:OFFSET_BITS];
    assign w_full          = (r_count == c_FULL);
    // The byte offset within a line never affects buffer behaviour.
    assign w_unused_offset = ^mem_address[OFFSET_BITS-1:0];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] && (r_tag[gi] == w_tag);
        end
    endgenerate

    // Encode the matching slot; coalescing keeps tags unique so at most one bit is set.
    always_comb begin
        w_hit     = |w_match;
        w_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i]) begin
                w_hit_idx = c_PTR_W'(i);
            end
        end
    end

    // Control FSM: owns entry storage, pointers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_valid         <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
            r_mem_resp      <= 1'b0;
            r_mem_line_read <= '0;
            r_read          <= 1'b0;
            r_write         <= 1'b0;
            r_address       <= '0;
            r_line          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_read) begin
                        if (w_hit) begin
                            r_mem_line_read <= r_data[w_hit_idx];
                            r_mem_resp      <= 1'b1;
                            r_state         <= S_RESP;
                        end else begin
                            r_read    <= 1'b1;
                            r_address <= {w_tag, c_OFFSET_ZERO};
                            r_state   <= S_FWD_READ;
                        end
                    end else if (mem_write && w_hit) begin
                        // Coalesce into the existing entry; occupancy unchanged.
                        r_data[w_hit_idx] <= mem_line_write;
                        r_mem_resp        <= 1'b1;
                        r_state           <= S_RESP;
                    end else if (mem_write && !w_full) begin
                        r_valid[r_tail] <= 1'b1;
                        r_tag[r_tail]   <= w_tag;
                        r_data[r_tail]  <= mem_line_write;
                        r_tail          <= r_tail + c_PTR_ONE;
                        r_count         <= r_count + c_CNT_ONE;
                        r_mem_resp      <= 1'b1;
                        r_state         <= S_RESP;
                    end else if (r_count != '0) begin
                        // Idle drain, or a forced drain to make room for a
                        // write that stays pending until a later IDLE visit.
                        r_write   <= 1'b1;
                        r_address <= {r_tag[r_head], c_OFFSET_ZERO};
                        r_line    <= r_data[r_head];
                        r_state   <= S_DRAIN;
                    end
                end

                S_FWD_READ: begin
                    if (resp_i) begin
                        r_read          <= 1'b0;
                        r_address       <= '0;
                        r_mem_line_read <= line_i;
                        r_mem_resp      <= 1'b1;
                        r_state         <= S_RESP;
                    end
                end

                S_DRAIN: begin
                    if (resp_i) begin
                        r_write         <= 1'b0;
                        r_address       <= '0;
                        r_line          <= '0;
                        r_valid[r_head] <= 1'b0;
                        r_head          <= r_head + c_PTR_ONE;
                        r_count         <= r_count - c_CNT_ONE;
                        r_state         <= S_IDLE;
                    end
                end

                S_RESP: begin
                    r_mem_resp <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_resp      = r_mem_resp;
    assign mem_line_read = r_mem_line_read;
    assign read_o        = r_read;
    assign write_o       = r_write;
    assign address_o     = r_address;
    assign line_o        = r_line;

endmodule
`default_nettype wire

// File: tb/tb_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_buffer
// Brief    : Self-checking bench for writeback_buffer. A table of upstream
//            operations with expected latency/read data is replayed, then the
//            downstream transaction log is compared with an expected table.
//            Hand-written sequence covers reset during an active drain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_buffer;

    localparam int DS_LAT = 2;
    localparam int N_OPS  = 10;
    localparam int N_DS   = 8;

    localparam logic [255:0] c_AA = {32{8'hAA}};
    localparam logic [255:0] c_D1 = {8{32'h1111_0001}};
    localparam logic [255:0] c_E1 = {8{32'hE1E1_0001}};
    localparam logic [255:0] c_E2 = {8{32'hE2E2_0002}};
    localparam logic [255:0] c_P  = {8{32'h5050_0505}};
    localparam logic [255:0] c_A2 = {8{32'h0200_A2A2}};
    localparam logic [255:0] c_B2 = {8{32'h0240_B2B2}};
    localparam logic [255:0] c_C2 = {8{32'h0280_C2C2}};
    localparam logic [255:0] c_Q  = {8{32'h0700_7777}};

    typedef struct {
        bit           rd;
        bit           chain;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp_line;
        int           exp_lat;
    } vec_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } ds_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_line_write;
    logic [255:0] mem_line_read;
    logic         mem_resp;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [255:0] line_o;
    logic [255:0] line_i;
    logic         resp_i;

    int   total = 0;
    int   bad   = 0;
    bit   hold_down = 1'b0;

    ds_t          ds_log[$];
    ds_t          ent;
    int           ds_cnt;
    logic [31:0]  ds_addr0;
    logic [255:0] ds_line0;

    vec_t ops    [N_OPS];
    ds_t  exp_ds [N_DS];

    writeback_buffer #(.DEPTH(2), .OFFSET_BITS(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_line_write (mem_line_write),
        .mem_line_read  (mem_line_read),
        .mem_resp       (mem_resp),
        .address_o      (address_o),
        .read_o         (read_o),
        .write_o        (write_o),
        .line_o         (line_o),
        .line_i         (line_i),
        .resp_i         (resp_i)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rd_line_for(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one upstream request and wait (bounded) for mem_resp.
    task automatic up_op(input bit rd, input logic [31:0] addr, input logic [255:0] wdata,
                         output int lat, output logic [255:0] line);
        mem_address    = addr;
        mem_line_write = wdata;
        mem_read       = rd;
        mem_write      = !rd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_resp && lat < 40);
        line      = mem_line_read;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Downstream model: answers read_o/write_o after DS_LAT cycles and logs each transaction.
    initial begin
        resp_i = 1'b0;
        line_i = '0;
        ds_cnt = 0;
        forever begin
            @(negedge clk);
            if (resp_i) begin
                resp_i = 1'b0;
            end else if (!hold_down && !rst && (read_o || write_o)) begin
                if (ds_cnt == 0) begin
                    ds_addr0 = address_o;
                    ds_line0 = line_o;
                end
                if (ds_cnt == DS_LAT) begin
                    ent.wr   = write_o;
                    ent.addr = address_o;
                    if (read_o) begin
                        line_i   = rd_line_for(address_o);
                        ent.data = line_i;
                    end else begin
                        ent.data = line_o;
                    end
                    total++;
                    if ((read_o && write_o) || address_o !== ds_addr0 ||
                        (write_o && line_o !== ds_line0)) begin
                        bad++;
                        $display("FAIL ds_stable: got addr %h rd %b wr %b want addr %h single request",
                                 address_o, read_o, write_o, ds_addr0);
                    end
                    ds_log.push_back(ent);
                    resp_i = 1'b1;
                    ds_cnt = 0;
                end else begin
                    ds_cnt++;
                end
            end else begin
                ds_cnt = 0;
            end
        end
    end

    initial begin
        int           lat;
        int           w;
        int           log_sz;
        logic [255:0] line;

        // rd, chain, addr, wdata, exp_line, exp_lat
        ops[0] = '{1'b0, 1'b0, 32'h0000_1020, c_AA, '0, 1};
        ops[1] = '{1'b0, 1'b0, 32'h0000_0100, c_D1, '0, 1};
        ops[2] = '{1'b1, 1'b1, 32'h0000_011F, '0, c_D1, 2};
        ops[3] = '{1'b0, 1'b0, 32'h0000_0300, c_E1, '0, 1};
        ops[4] = '{1'b0, 1'b1, 32'h0000_0300, c_E2, '0, 2};
        ops[5] = '{1'b0, 1'b0, 32'h0000_0500, c_P,  '0, 1};
        ops[6] = '{1'b1, 1'b1, 32'h0000_0400, '0, rd_line_for(32'h0000_0400), 5};
        ops[7] = '{1'b0, 1'b0, 32'h0000_0200, c_A2, '0, 1};
        ops[8] = '{1'b0, 1'b1, 32'h0000_0240, c_B2, '0, 2};
        ops[9] = '{1'b0, 1'b1, 32'h0000_0280, c_C2, '0, 6};

        exp_ds[0] = '{1'b1, 32'h0000_1020, c_AA};
        exp_ds[1] = '{1'b1, 32'h0000_0100, c_D1};
        exp_ds[2] = '{1'b1, 32'h0000_0300, c_E2};
        exp_ds[3] = '{1'b0, 32'h0000_0400, rd_line_for(32'h0000_0400)};
        exp_ds[4] = '{1'b1, 32'h0000_0500, c_P};
        exp_ds[5] = '{1'b1, 32'h0000_0200, c_A2};
        exp_ds[6] = '{1'b1, 32'h0000_0240, c_B2};
        exp_ds[7] = '{1'b1, 32'h0000_0280, c_C2};

        rst            = 1'b1;
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_line_write = '0;

        repeat (3) @(negedge clk);
        chk("rst_mem_resp",      256'(mem_resp),  '0);
        chk("rst_mem_line_read", mem_line_read,   '0);
        chk("rst_read_o",        256'(read_o),    '0);
        chk("rst_write_o",       256'(write_o),   '0);
        chk("rst_address_o",     256'(address_o), '0);
        chk("rst_line_o",        line_o,          '0);
        rst = 1'b0;

        // Chained ops start in the RESP cycle of the previous op, so the
        // DUT spends one extra cycle returning to IDLE before sampling.
        for (int i = 0; i < N_OPS; i++) begin
            if (!ops[i].chain) repeat (12) @(negedge clk);
            up_op(ops[i].rd, ops[i].addr, ops[i].wdata, lat, line);
            chk($sformatf("op%0d_lat", i), 256'(lat), 256'(ops[i].exp_lat));
            if (ops[i].rd) chk($sformatf("op%0d_line", i), line, ops[i].exp_line);
        end

        repeat (30) @(negedge clk);
        chk("ds_count", 256'(ds_log.size()), 256'(N_DS));
        for (int i = 0; i < N_DS; i++) begin
            if (i < ds_log.size()) begin
                chk($sformatf("ds%0d_wr", i),   256'(ds_log[i].wr),   256'(exp_ds[i].wr));
                chk($sformatf("ds%0d_addr", i), 256'(ds_log[i].addr), 256'(exp_ds[i].addr));
                chk($sformatf("ds%0d_data", i), ds_log[i].data,       exp_ds[i].data);
            end
        end

        // Reset while a drain is outstanding and unanswered.
        hold_down = 1'b1;
        repeat (12) @(negedge clk);
        log_sz = ds_log.size();
        up_op(1'b0, 32'h0000_0700, c_Q, lat, line);
        chk("q_write_lat", 256'(lat), 256'(1));
        w = 0;
        while (!write_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("q_drain_started", 256'(write_o), 256'(1));
        chk("q_drain_addr",    256'(address_o), 256'(32'h0000_0700));
        #2 rst = 1'b1;
        #1;
        chk("arst_write_o",   256'(write_o),   '0);
        chk("arst_mem_resp",  256'(mem_resp),  '0);
        chk("arst_address_o", 256'(address_o), '0);
        chk("arst_line_o",    line_o,          '0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        hold_down = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_stale_drain", 256'(ds_log.size()), 256'(log_sz));

        // The abandoned entry must be gone: reading it misses to downstream.
        up_op(1'b1, 32'h0000_0700, '0, lat, line);
        chk("post_rst_read_lat",  256'(lat), 256'(4));
        chk("post_rst_read_line", line, rd_line_for(32'h0000_0700));
        chk("post_rst_ds_count",  256'(ds_log.size()), 256'(log_sz + 1));
        if (ds_log.size() == log_sz + 1) begin
            chk("post_rst_ds_wr",   256'(ds_log[log_sz].wr),   '0);
            chk("post_rst_ds_addr", 256'(ds_log[log_sz].addr), 256'(32'h0000_0700));
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
